// File: rtl/linebuffer_pkg.sv
// Shared constants for the ping-pong line buffer: default geometry and FSM state encoding.
// The optional clear sequencer is enabled by defining LINEBUFFER_CLEAR_EN.
package linebuffer_pkg;

    localparam int unsigned LB_LANES = 16;
    localparam int unsigned LB_PIX_W = 8;
    localparam int unsigned LB_DEPTH = 128;

    typedef logic [0:0] lb_state_t;

    localparam lb_state_t ST_IDLE  = 1'b0;
    localparam lb_state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/linebuffer_pingpong_if.sv
// Draw-side write channel into the back bank of the ping-pong line buffer.
interface linebuffer_pingpong_if
    import linebuffer_pkg::*;
#(
    parameter int unsigned LANES = LB_LANES,
    parameter int unsigned PIX_W = LB_PIX_W,
    parameter int unsigned AW    = $clog2(LB_DEPTH)
);
    logic                   draw_valid;
    logic                   draw_ready;
    logic [AW-1:0]          addr_draw;
    logic [LANES-1:0]       we_draw;
    logic [LANES*PIX_W-1:0] colour_draw;

    modport master (
        output draw_valid,
        output addr_draw,
        output we_draw,
        output colour_draw,
        input  draw_ready
    );

    modport slave (
        input  draw_valid,
        input  addr_draw,
        input  we_draw,
        input  colour_draw,
        output draw_ready
    );
endinterface

// File: rtl/linebuffer_bank.sv
// One line-buffer bank: DEPTH words of LANES pixels, per-lane write enable, registered read.
module linebuffer_bank
    import linebuffer_pkg::*;
#(
    parameter int unsigned LANES = LB_LANES,
    parameter int unsigned PIX_W = LB_PIX_W,
    parameter int unsigned DEPTH = LB_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned W    = LANES * PIX_W
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [LANES-1:0] we,
    input  logic [AW-1:0]    waddr,
    input  logic [W-1:0]     wdata,
    input  logic [AW-1:0]    raddr,
    output logic [W-1:0]     rdata
);
    logic [W-1:0] mem [DEPTH];

    // Per-lane writes; storage is never reset.
    always_ff @(posedge clk_pix) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
                mem[waddr][i*PIX_W +: PIX_W] <= wdata[i*PIX_W +: PIX_W];
            end
        end
    end

    // Registered read returns the word as it stood before this edge's writes.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/linebuffer_pingpong.sv
// Ping-pong scanout line buffer: draw into the back bank, scan out the front bank, swap on request.
// Define LINEBUFFER_CLEAR_EN to add a sequencer that fills the new back bank with clear_colour after
// every swap (and after reset), holding off draws and deferring one swap request while it runs.
module linebuffer_pingpong
    import linebuffer_pkg::*;
#(
    parameter int unsigned LANES = LB_LANES,
    parameter int unsigned PIX_W = LB_PIX_W,
    parameter int unsigned DEPTH = LB_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned W    = LANES * PIX_W
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    input  logic [AW-1:0]         addr_pix,
    output logic [W-1:0]          colour_pix,
    linebuffer_pingpong_if.slave  draw,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  front_sel,
    output logic                  clear_busy,
    input  logic [PIX_W-1:0]      clear_colour
);
    logic             front_sel_nxt;
    logic             swap_ack_nxt;
    logic             front_sel_d;
    logic [LANES-1:0] wr_we;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic [W-1:0]     rd0;
    logic [W-1:0]     rd1;

`ifdef LINEBUFFER_CLEAR_EN
    lb_state_t     state;
    lb_state_t     state_nxt;
    logic          swap_pend;
    logic          swap_pend_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] clr_cnt_nxt;

    assign clear_busy = (state == ST_CLEAR);
`else
    logic unused_clear_colour;

    assign unused_clear_colour = ^clear_colour;
    assign clear_busy          = 1'b0;
`endif

    assign draw.draw_ready = ~clear_busy;

    // Next-state, swap decision and back-bank write port selection.
    always_comb begin
        front_sel_nxt = front_sel;
        swap_ack_nxt  = 1'b0;
        wr_we         = '0;
        wr_addr       = draw.addr_draw;
        wr_data       = draw.colour_draw;
`ifdef LINEBUFFER_CLEAR_EN
        state_nxt     = state;
        swap_pend_nxt = swap_pend;
        clr_cnt_nxt   = clr_cnt;
        case (state)
            ST_IDLE: begin
                if (draw.draw_valid) begin
                    wr_we = draw.we_draw;
                end
                if (swap_req || swap_pend) begin
                    front_sel_nxt = ~front_sel;
                    swap_pend_nxt = 1'b0;
                    swap_ack_nxt  = 1'b1;
                    clr_cnt_nxt   = '0;
                    state_nxt     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                wr_we       = '1;
                wr_addr     = clr_cnt;
                wr_data     = {LANES{clear_colour}};
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (swap_req) begin
                    swap_pend_nxt = 1'b1;
                end
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
`else
        if (draw.draw_valid) begin
            wr_we = draw.we_draw;
        end
        if (swap_req) begin
            front_sel_nxt = ~front_sel;
            swap_ack_nxt  = 1'b1;
        end
`endif
        if (rst_pix) begin
            wr_we = '0;
        end
    end

    // Control registers.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            front_sel   <= 1'b0;
            front_sel_d <= 1'b0;
            swap_ack    <= 1'b0;
`ifdef LINEBUFFER_CLEAR_EN
            state       <= ST_CLEAR;
            swap_pend   <= 1'b0;
            clr_cnt     <= '0;
`endif
        end else begin
            front_sel   <= front_sel_nxt;
            front_sel_d <= front_sel;
            swap_ack    <= swap_ack_nxt;
`ifdef LINEBUFFER_CLEAR_EN
            state       <= state_nxt;
            swap_pend   <= swap_pend_nxt;
            clr_cnt     <= clr_cnt_nxt;
`endif
        end
    end

    linebuffer_bank #(.LANES(LANES), .PIX_W(PIX_W), .DEPTH(DEPTH)) u_bank0 (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .we      (front_sel ? wr_we : '0),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr   (addr_pix),
        .rdata   (rd0)
    );

    linebuffer_bank #(.LANES(LANES), .PIX_W(PIX_W), .DEPTH(DEPTH)) u_bank1 (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .we      (front_sel ? '0 : wr_we),
        .waddr   (wr_addr),
        .wdata   (wr_data),
        .raddr   (addr_pix),
        .rdata   (rd1)
    );

    // Bank read data lags the address by one cycle, so select with the delayed front index.
    assign colour_pix = front_sel_d ? rd1 : rd0;
endmodule

// File: doc/linebuffer_pingpong.md
LINEBUFFER_PINGPONG -- requirements
Module: linebuffer_pingpong

Interface
REQ-001 SHALL have parameter LANES, default 16: pixels per memory word.
REQ-002 SHALL have parameter PIX_W, default 8: bits per pixel.
REQ-003 SHALL have parameter DEPTH, default 128: words per bank, power of two; AW = clog2(DEPTH).
REQ-004 SHALL have port clk_pix  in  1: the single clock for all logic.
REQ-005 SHALL have port rst_pix  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port addr_pix  in  AW: scanout read address into the front bank.
REQ-007 SHALL have port colour_pix  out  LANES*PIX_W: scanout read data.
REQ-008 SHALL have port draw_valid  in  1: a draw write is presented.
REQ-009 SHALL have port draw_ready  out  1: a draw write can be accepted.
REQ-010 SHALL have port addr_draw  in  AW: draw write address into the back bank.
REQ-011 SHALL have port we_draw  in  LANES: per-pixel write enables.
REQ-012 SHALL have port colour_draw  in  LANES*PIX_W: draw write data.
REQ-013 SHALL have port swap_req  in  1: request to exchange the front and back banks.
REQ-014 SHALL have port swap_ack  out  1: one-cycle pulse confirming that a swap has executed.
REQ-015 SHALL have port front_sel  out  1: index of the bank currently being scanned out.
REQ-016 SHALL have port clear_busy  out  1: the back-bank clear sequencer is running.
REQ-017 SHALL have port clear_colour  in  PIX_W: fill value used by the clear sequencer.

Function
REQ-018 SHALL hold two banks of DEPTH x LANES*PIX_W; bank front_sel is the front bank and the other bank is the back bank.
REQ-019 SHALL register colour_pix one cycle after addr_pix is sampled, reading from the front bank as it was at that sampling edge.
REQ-020 SHALL write pixel i of colour_draw to back[addr_draw] on an edge where draw_valid && draw_ready && we_draw[i]; pixels with cleared enables are left unchanged.
REQ-021 SHALL execute a swap on an edge where the FSM is in IDLE and (swap_req or swap_pend) is set: front_sel toggles, swap_pend clears, and swap_ack is 1 for the following cycle only.
REQ-022 SHALL direct a draw write accepted on the swap edge to the pre-swap back bank, which becomes the new front bank.
REQ-023 SHALL set swap_pend when swap_req arrives in CLEAR; multiple requests collapse into one pending swap.
REQ-024 SHALL implement FSM states IDLE and CLEAR; transitions are IDLE->CLEAR on the swap edge and CLEAR->IDLE after the write to address DEPTH-1.
REQ-025 SHALL, in CLEAR, write clear_colour to all lanes of back[clr_cnt] each cycle, with clr_cnt running 0..DEPTH-1 and then wrapping to 0; a clear therefore lasts exactly DEPTH cycles.
REQ-026 SHALL drive clear_busy = (state==CLEAR) and draw_ready = !clear_busy.
REQ-027 SHALL execute a pending swap on the first IDLE edge after the clear completes; there is no idle gap.
REQ-028 SHALL keep scanout reads unaffected by clearing, because reads and clears always target different banks.

Reset
REQ-029 SHALL on rst_pix set front_sel=0, swap_ack=0, swap_pend=0, clr_cnt=0 and colour_pix=0.
REQ-030 SHALL on rst_pix enter CLEAR (clearing bank 1) when LINEBUFFER_CLEAR_EN is defined, and enter IDLE otherwise.
REQ-031 SHALL abort any clear in progress when reset is asserted mid-operation; bank contents are not reset.

Configuration
REQ-032 SHALL compile in the clear sequencer only when LINEBUFFER_CLEAR_EN is defined.
REQ-033 SHALL, when LINEBUFFER_CLEAR_EN is undefined, tie clear_busy to 0 and draw_ready to 1, omit swap_pend, execute every swap_req immediately with an ack, and leave clear_colour unused.

Structure
REQ-034 SHALL place the FSM state enum and the default parameter constants in package linebuffer_pkg.
REQ-035 SHALL instantiate sub-module linebuffer_bank twice; each instance is a single bank with a per-lane write enable and a registered read.
REQ-036 SHALL select colour_pix from the two bank outputs using front_sel delayed by one cycle.

Verification
REQ-037 SHALL cover: reset without macro, write addr 5 all lanes 0xA5, swap -> swap_ack 1 cycle later, front_sel=1, colour_pix at addr 5 = all 0xA5.
REQ-038 SHALL cover: we_draw=16'h0001, data 0x11 over prior 0xA5 -> lane 0 = 0x11, lanes 1..15 = 0xA5.
REQ-039 SHALL cover: with macro, clear_colour=0x00, swap -> clear_busy high for exactly 128 cycles, draw_ready low during that window, back bank reads all 0x00 after the next swap.
REQ-040 SHALL cover: with macro, swap_req pulsed 3 times mid-clear -> exactly one swap_ack, on the cycle after the clear ends.
REQ-041 SHALL cover: draw write to addr 7 on the swap edge -> the data appears at front addr 7 on the next read.
REQ-042 SHALL cover: rst_pix asserted at clr_cnt=40 -> clr_cnt=0, front_sel=0, and a fresh 128-cycle clear of bank 1 with the macro defined.
